// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the ring-FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Cyclic first-set search: lowest-offset set bit of req at or after start.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return IW'(s);
  endfunction

  // scan offsets 0..N-1 from start, first hit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_add(start, k)]) begin
        found = 1'b1;
        idx   = wrap_add(start, k);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding NUM_REQ writers into one ring FIFO.
// Optional per-writer accept counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_datain,
  input  logic                          fifo_full,
  output logic [NUM_REQ*STAT_W-1:0]     stat_cnt
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  state_t          state, state_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n;
  logic [BW-1:0]   bcnt, bcnt_n;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IW'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return i + IW'(1);
    end
  endfunction

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // arbitration state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      bcnt   <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      rr_ptr <= rr_ptr_n;
      bcnt   <= bcnt_n;
    end
  end

  // next state and grant; a full FIFO freezes everything, including burst end
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    bcnt_n   = bcnt;
    gnt_vld  = 1'b0;
    gnt_idx  = owner;
    if (reset || fifo_full) begin
      gnt_vld = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt_vld = 1'b1;
            gnt_idx = pick_idx;
            owner_n = pick_idx;
            bcnt_n  = BW'(1);
            if (MAX_BURST > 1) begin
              state_n = BURST;
            end else begin
              rr_ptr_n = next_idx(pick_idx);
            end
          end else begin
            state_n = IDLE;
          end
        end
        BURST: begin
          // the cycle after the last word (or a dropped request) is the gap
          if ((bcnt == BW'(MAX_BURST)) || !req[owner]) begin
            state_n  = IDLE;
            rr_ptr_n = next_idx(owner);
          end else begin
            gnt_vld = 1'b1;
            gnt_idx = owner;
            bcnt_n  = bcnt + BW'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // one-hot grant decode and data mux
  always_comb begin
    gnt         = '0;
    fifo_datain = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i]      = gnt_vld && (gnt_idx == IW'(i));
      fifo_datain = fifo_datain | (gnt[i] ? data[i*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
  end

  assign fifo_write = |gnt;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] cnt [NUM_REQ];

  // saturating per-writer accept counters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (cnt[i] != STAT_MAX)) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_cnt[g*STAT_W +: STAT_W] = cnt[g];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        fifo_write;
  logic [7:0]  fifo_datain;
  logic        fifo_full;
  logic [63:0] stat_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .data        (data),
    .gnt         (gnt),
    .fifo_write  (fifo_write),
    .fifo_datain (fifo_datain),
    .fifo_full   (fifo_full),
    .stat_cnt    (stat_cnt)
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic        wr;
    logic [7:0]  din;
    logic [63:0] stat;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        ob;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] mdl_cnt [4];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // drive one cycle of stimulus and queue what the outputs must be in it
  task automatic step(input logic rst, input logic [3:0] r, input logic f, input logic [3:0] eg);
    exp_t        e;
    logic [31:0] d;
    d         = $urandom();
    reset     = rst;
    req       = r;
    fifo_full = f;
    data      = d;
    e.gnt  = eg;
    e.wr   = |eg;
    e.din  = 8'h00;
    e.stat = 64'h0;
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) e.din = d[i*8 +: 8];
`ifdef FIFO_ARB_STATS_EN
      e.stat[i*16 +: 16] = mdl_cnt[i];
`endif
    end
    sb_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      if (rst) mdl_cnt[i] = 16'h0;
      else if (eg[i] && mdl_cnt[i] != 16'hFFFF) mdl_cnt[i] = mdl_cnt[i] + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      ob = sb_q.pop_front();
      check_val("gnt", {60'h0, gnt}, {60'h0, ob.gnt});
      check_val("fifo_write", {63'h0, fifo_write}, {63'h0, ob.wr});
      check_val("fifo_datain", {56'h0, fifo_datain}, {56'h0, ob.din});
      check_val("stat_cnt", stat_cnt, ob.stat);
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic        s_reset;
  logic [3:0]  s_gnt;
  logic        s_write;
  logic [7:0]  s_din;
  logic [63:0] s_stat;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(16)) dut_sat (
    .clk         (clk),
    .reset       (s_reset),
    .req         (4'b1000),
    .data        (32'hA5A5_A5A5),
    .gnt         (s_gnt),
    .fifo_write  (s_write),
    .fifo_datain (s_din),
    .fifo_full   (1'b0),
    .stat_cnt    (s_stat)
  );
`endif

  initial begin
    logic [3:0] eg;
    for (int i = 0; i < 4; i++) mdl_cnt[i] = 16'h0;
    reset     = 1'b1;
    req       = 4'b0000;
    data      = 32'h0;
    fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    s_reset = 1'b1;
`endif
    @(posedge clk);
    #1;

    // reset cycles: no grant even with every writer requesting
    step(1'b1, 4'b1111, 1'b0, 4'b0000);
    step(1'b1, 4'b1111, 1'b0, 4'b0000);

    // single writer: 4-word burst, one gap, next burst
    for (int c = 0; c < 6; c++) step(1'b0, 4'b0001, 1'b0, (c == 4) ? 4'b0000 : 4'b0001);
    step(1'b0, 4'b0000, 1'b0, 4'b0000);
    step(1'b1, 4'b0000, 1'b0, 4'b0000);

    // all writers: 0x4, 1x4, 2x4, 3x4, 0x4 with one gap per burst
    for (int c = 0; c < 25; c++) begin
      eg = 4'b0001 << ((c / 5) % 4);
      step(1'b0, 4'b1111, 1'b0, ((c % 5) < 4) ? eg : 4'b0000);
    end

    // writer 1 drops after 2 words; next requester after 1 is 3
    step(1'b0, 4'b1011, 1'b0, 4'b0010);
    step(1'b0, 4'b1011, 1'b0, 4'b0010);
    step(1'b0, 4'b1001, 1'b0, 4'b0000);
    for (int c = 0; c < 4; c++) step(1'b0, 4'b1001, 1'b0, 4'b1000);
    step(1'b0, 4'b1001, 1'b0, 4'b0000);
    step(1'b0, 4'b1001, 1'b0, 4'b0001);
    step(1'b0, 4'b0000, 1'b0, 4'b0000);

    // FIFO full for 3 cycles at bcnt=2 of writer 2, then exactly 2 more words
    step(1'b0, 4'b0100, 1'b0, 4'b0100);
    step(1'b0, 4'b0100, 1'b0, 4'b0100);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0100, 1'b1, 4'b0000);
    step(1'b0, 4'b0100, 1'b0, 4'b0100);
    step(1'b0, 4'b0100, 1'b0, 4'b0100);
    step(1'b0, 4'b0100, 1'b0, 4'b0000);
    step(1'b0, 4'b0100, 1'b1, 4'b0000);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0100, 1'b0, 4'b0100);

    // reset at bcnt=3 aborts the burst; lowest requester wins afterwards
    step(1'b1, 4'b0110, 1'b0, 4'b0000);
    step(1'b0, 4'b0110, 1'b0, 4'b0010);
    step(1'b0, 4'b0000, 1'b0, 4'b0000);

    check_val("sb_drain", 64'(sb_q.size()), 64'h0);

`ifdef FIFO_ARB_STATS_EN
    s_reset = 1'b0;
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk);
    end
    #1;
    check_val("stat_sat_w3", {48'h0, s_stat[48 +: 16]}, 64'h0000_0000_0000_FFFF);
    check_val("stat_sat_w012", {16'h0, s_stat[47:0]}, 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of writer ports (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the word width, matching the downstream ring FIFO.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive accepted words per grant (1..16).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-writer request; bit i set means data slice i is valid.
REQ-007 data  input  NUM_REQ*DATA_WIDTH  per-writer word; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 gnt  output  NUM_REQ  one-hot accept strobe; gnt[i]=1 means slice i is written this cycle.
REQ-009 fifo_write  output  1  write strobe to the ring FIFO.
REQ-010 fifo_datain  output  DATA_WIDTH  word to the ring FIFO.
REQ-011 fifo_full  input  1  full flag from the ring FIFO.
REQ-012 stat_cnt  output  NUM_REQ*16  per-writer accepted-word counters (see Configuration).

Function
REQ-013 gnt SHALL be combinational from req, fifo_full and registered state, with zero-cycle latency: a word is accepted in the cycle its gnt bit is high.
REQ-014 gnt SHALL be all-zero whenever fifo_full=1, regardless of any simultaneous read at the FIFO.
REQ-015 fifo_write SHALL equal OR-reduce(gnt), and fifo_datain SHALL equal data slice of the granted writer, or zero when none is granted.
REQ-016 The FSM SHALL have states IDLE and BURST plus a registered owner index, a round-robin pointer rr_ptr, and a burst counter bcnt.
REQ-017 In IDLE with fifo_full=0, the block SHALL grant the first requester at or after rr_ptr in ascending cyclic order, load owner, set bcnt=1, and go to BURST if MAX_BURST>1, else stay in IDLE.
REQ-018 In BURST, the block SHALL grant only owner while req[owner]=1 and fifo_full=0, incrementing bcnt per accepted word.
REQ-019 A burst SHALL end, with return to IDLE and rr_ptr=owner+1 modulo NUM_REQ, when an accept brings bcnt to MAX_BURST or when req[owner]=0. No grant SHALL be issued in the cycle req[owner] drops.
REQ-020 The block SHALL hold state, bcnt and rr_ptr unchanged while fifo_full=1. A full FIFO SHALL never end a burst.
REQ-021 When a single-word grant is issued from IDLE with MAX_BURST=1, rr_ptr SHALL advance to the granted index+1.
REQ-022 rr_ptr wrap-around SHALL be NUM_REQ-1 -> 0. bcnt SHALL be $clog2(MAX_BURST+1) bits wide.

Reset
REQ-023 On reset, the block SHALL set state=IDLE, rr_ptr=0, owner=0, bcnt=0 and stat_cnt=0. gnt and fifo_write SHALL be 0 in the reset cycle.
REQ-024 Reset asserted mid-burst SHALL abort the burst. No partial-state carry-over SHALL occur.

Configuration
REQ-025 With macro FIFO_ARB_STATS_EN defined, each stat_cnt slice i SHALL increment by 1 per cycle with gnt[i]=1 and saturate at 16'hFFFF.
REQ-026 Without FIFO_ARB_STATS_EN, the counters SHALL not be built and stat_cnt SHALL be tied to 0.

Structure
REQ-027 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST), the STAT_W=16 constant and the saturation constant.
REQ-028 The cyclic first-set search SHALL be a sub-module rr_pick (inputs: req vector and start pointer; outputs: found flag and index), instantiated once.

Verification
REQ-029 Scenario: NUM_REQ=4, MAX_BURST=4, reset, req=4'b0001 held for 6 cycles -> gnt[0] for 4 cycles, 1 idle cycle, then gnt[0] again, rr_ptr=1 after the first burst.
REQ-030 Scenario: req=4'b1111 held, FIFO never full -> grant order 0x4, 1x4, 2x4, 3x4, 0x4 with no gaps except the one IDLE re-arbitration cycle per burst.
REQ-031 Scenario: fifo_full=1 for 3 cycles mid-burst of writer 2 at bcnt=2 -> gnt=0 for those cycles, then writer 2 resumes and gets exactly 2 more words.
REQ-032 Scenario: writer 1 drops req after 2 words -> burst ends, and the next grant goes to the next requesting index after 1.
REQ-033 Scenario: reset asserted while in BURST at bcnt=3 -> next cycle IDLE, rr_ptr=0, stat_cnt=0, and the first grant goes to the lowest requesting index.
REQ-034 Scenario: with FIFO_ARB_STATS_EN, 70000 accepts on writer 3 -> stat_cnt[3]=16'hFFFF. Without the macro, stat_cnt stays 0.
